controlador_posicionamento: RTL and testbench
=============================================

Name: controlador_posicionamento

Overview:
Sequences the ship-placement validator during the setup phase. Walks both players through their fleets in fixed type order, latches each player-entered placement, drives the validator with it, waits for its ready, and accepts or rejects the placement. Sits between the player input/debounce logic and the validator. On acceptance it emits a commit pulse so the board-memory write path stores the validator's vetor.

Parameters:
NUM_NAVIOS, 5, ships per player; types 0..NUM_NAVIOS-1 are placed in ascending order.
TIMEOUT, 64, cycles allowed between raising val_enable and seeing val_ready.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  one-cycle pulse that begins the setup phase
confirma  input  1  one-cycle pulse: player placement fields are valid
x_in  input  4  column of the ship's first cell
y_in  input  4  row of the ship's first cell
direcao_in  input  1  placement direction
orientacao_in  input  3  placement orientation
val_ready  input  1  validator finished
val_conflitoBorda  input  1  validator: board-edge conflict
val_conflitoMemoria  input  1  validator: overlap with stored ship
val_enable  output  1  validator enable
val_tipo  output  3  ship type under validation
val_direcao  output  1  latched direcao_in
val_orientacao  output  3  latched orientacao_in
val_x1  output  4  latched x_in
val_y1  output  4  latched y_in
val_jogador  output  1  current player, 0 or 1
pedir_entrada  output  1  waiting for confirma
commit  output  1  one-cycle pulse: accepted placement, write vetor
erro_borda  output  1  last attempt rejected for an edge conflict
erro_memoria  output  1  last attempt rejected for an overlap
erro_timeout  output  1  last attempt got no ready
navios_colocados  output  3  ships accepted for the current player
fase_concluida  output  1  both fleets placed, held until reset

Behaviour:
- Reset (async, any state): state OCIOSO. Every output is 0, including val_tipo, val_jogador, the latched fields and the error flags.
- States: OCIOSO, ESPERA_ENTRADA, VALIDA, AGUARDA_READY, LIBERA, TROCA_JOGADOR, CONCLUIDO.
- OCIOSO: on start go to ESPERA_ENTRADA. Load jogador=0, tipo=0, navios_colocados=0.
- ESPERA_ENTRADA: pedir_entrada=1. When confirma=1, latch x_in, y_in, direcao_in and orientacao_in into val_*, clear all error flags, and go to VALIDA. confirma is ignored in every other state.
- VALIDA: one cycle with val_enable=0, so the validator always sees a rising enable. Clear the timeout counter, then go to AGUARDA_READY.
- AGUARDA_READY: val_enable=1 and the counter increments each cycle.
  - If val_ready=1, sample the conflict inputs in that same cycle.
  - Either conflict set: set erro_borda and/or erro_memoria to match the inputs (both may set), then go to LIBERA without accepting.
  - No conflict: pulse commit=1 for exactly one cycle, increment navios_colocados and tipo, then go to LIBERA.
  - If the counter reaches TIMEOUT-1 with no ready: set erro_timeout, then go to LIBERA.
  - If val_ready and the timeout coincide, ready wins.
- LIBERA: val_enable=0 for one cycle, then:
  - After an accepted placement of type NUM_NAVIOS-1: go to TROCA_JOGADOR.
  - Otherwise: go to ESPERA_ENTRADA. A rejected attempt retries the same tipo.
- TROCA_JOGADOR: one cycle.
  - jogador=0: set jogador=1, tipo=0, navios_colocados=0, then go to ESPERA_ENTRADA.
  - jogador=1: go to CONCLUIDO.
- CONCLUIDO: fase_concluida=1, everything else idle. start is ignored; only rst leaves this state.
- val_enable is high only in AGUARDA_READY.
- commit never asserts in a cycle where an error flag is being set.
- val_* fields are stable from VALIDA through LIBERA.
- Error flags persist until the next confirma or rst.
- navios_colocados saturates at NUM_NAVIOS and never wraps.
- Latency from confirma to val_enable is 2 cycles. Best case from confirma to commit is 3 cycles, when ready arrives on the first AGUARDA_READY cycle.
- rst asserted mid-validation drops val_enable asynchronously. No commit is issued.

Test Plan:
- Reset/idle: assert rst, then release. Every output is 0. No start for 20 cycles keeps val_enable=0 and pedir_entrada=0.
- Clean placement: start, then confirma with x=1, y=1, dir=0, ori=0. Model returns ready 3 cycles later with no conflicts. Expect val_enable high for 3 cycles with val_tipo=0, a single commit pulse, and navios_colocados=1. pedir_entrada=1 returns afterwards.
- Edge conflict: confirma with x=7, y=0, tipo 0, and the model asserts conflitoBorda with ready. Expect erro_borda=1, no commit, and val_tipo still 0. A retry with x=1, y=1 commits.
- Memory conflict plus timeout: conflitoMemoria with ready gives erro_memoria=1 only. Next, a model that never asserts ready gives erro_timeout=1 after exactly TIMEOUT=64 enable cycles, then val_enable=0.
- Full phase: 10 clean placements. Expect jogador to switch to 1 after the 5th commit and val_tipo to restart at 0. fase_concluida=1 after the 10th. Further confirma/start pulses produce no val_enable.
- Reset mid-operation: assert rst while in AGUARDA_READY. val_enable=0 in the same cycle, no commit, and state OCIOSO.

Source files
------------

// File: rtl/controlador_posicionamento.sv
// Setup-phase sequencer: walks both players through their fleets in type order,
// drives the placement validator and accepts or rejects each entered placement.
module controlador_posicionamento #(
    parameter int NUM_NAVIOS = 5,
    parameter int TIMEOUT    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       confirma,
    input  logic [3:0] x_in,
    input  logic [3:0] y_in,
    input  logic       direcao_in,
    input  logic [2:0] orientacao_in,
    input  logic       val_ready,
    input  logic       val_conflitoBorda,
    input  logic       val_conflitoMemoria,
    output logic       val_enable,
    output logic [2:0] val_tipo,
    output logic       val_direcao,
    output logic [2:0] val_orientacao,
    output logic [3:0] val_x1,
    output logic [3:0] val_y1,
    output logic       val_jogador,
    output logic       pedir_entrada,
    output logic       commit,
    output logic       erro_borda,
    output logic       erro_memoria,
    output logic       erro_timeout,
    output logic [2:0] navios_colocados,
    output logic       fase_concluida
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        OCIOSO,
        ESPERA_ENTRADA,
        VALIDA,
        AGUARDA_READY,
        LIBERA,
        TROCA_JOGADOR,
        CONCLUIDO
    } estado_t;

    estado_t       estado;
    estado_t       proximo;
    logic [CW-1:0] contador;
    logic [2:0]    tipo;
    logic          jogador;
    logic          expirou;
    logic          conflito;

    assign expirou  = (contador == CW'(TIMEOUT - 1));
    assign conflito = val_conflitoBorda | val_conflitoMemoria;

    // Status outputs decode the state register directly, so rst drops them at once.
    assign val_enable     = (estado == AGUARDA_READY);
    assign pedir_entrada  = (estado == ESPERA_ENTRADA);
    assign fase_concluida = (estado == CONCLUIDO);
    assign val_tipo       = tipo;
    assign val_jogador    = jogador;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO:         if (start) proximo = ESPERA_ENTRADA;
            ESPERA_ENTRADA: if (confirma) proximo = VALIDA;
            VALIDA:         proximo = AGUARDA_READY;
            AGUARDA_READY:  if (val_ready || expirou) proximo = LIBERA;
            // commit is high only in the LIBERA cycle that follows an acceptance,
            // and tipo has already advanced past the last ship type by then.
            LIBERA:         proximo = (commit && tipo == 3'(NUM_NAVIOS)) ? TROCA_JOGADOR
                                                                          : ESPERA_ENTRADA;
            TROCA_JOGADOR:  proximo = jogador ? CONCLUIDO : ESPERA_ENTRADA;
            CONCLUIDO:      proximo = CONCLUIDO;
            default:        proximo = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contador         <= '0;
            tipo             <= '0;
            jogador          <= 1'b0;
            navios_colocados <= '0;
            val_x1           <= '0;
            val_y1           <= '0;
            val_direcao      <= 1'b0;
            val_orientacao   <= '0;
            commit           <= 1'b0;
            erro_borda       <= 1'b0;
            erro_memoria     <= 1'b0;
            erro_timeout     <= 1'b0;
        end else begin
            commit <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (start) begin
                        jogador          <= 1'b0;
                        tipo             <= '0;
                        navios_colocados <= '0;
                    end
                end
                ESPERA_ENTRADA: begin
                    if (confirma) begin
                        val_x1         <= x_in;
                        val_y1         <= y_in;
                        val_direcao    <= direcao_in;
                        val_orientacao <= orientacao_in;
                        erro_borda     <= 1'b0;
                        erro_memoria   <= 1'b0;
                        erro_timeout   <= 1'b0;
                    end
                end
                VALIDA: contador <= '0;
                AGUARDA_READY: begin
                    contador <= contador + CW'(1);
                    // ready has priority over an expiring counter in the same cycle
                    if (val_ready) begin
                        if (conflito) begin
                            erro_borda   <= val_conflitoBorda;
                            erro_memoria <= val_conflitoMemoria;
                        end else begin
                            commit <= 1'b1;
                            tipo   <= tipo + 3'd1;
                            if (navios_colocados != 3'(NUM_NAVIOS))
                                navios_colocados <= navios_colocados + 3'd1;
                        end
                    end else if (expirou) begin
                        erro_timeout <= 1'b1;
                    end
                end
                TROCA_JOGADOR: begin
                    if (!jogador) begin
                        jogador          <= 1'b1;
                        tipo             <= '0;
                        navios_colocados <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_posicionamento.sv
// Randomized bench for controlador_posicionamento with a fleet-level reference model
// and a commit scoreboard.
module tb_controlador_posicionamento;

  localparam int NUM_NAVIOS = 5;
  localparam int TIMEOUT    = 64;
  localparam int W          = 13;

  logic       clk;
  logic       rst;
  logic       start;
  logic       confirma;
  logic [3:0] x_in;
  logic [3:0] y_in;
  logic       direcao_in;
  logic [2:0] orientacao_in;
  logic       val_ready;
  logic       val_conflitoBorda;
  logic       val_conflitoMemoria;
  logic       val_enable;
  logic [2:0] val_tipo;
  logic       val_direcao;
  logic [2:0] val_orientacao;
  logic [3:0] val_x1;
  logic [3:0] val_y1;
  logic       val_jogador;
  logic       pedir_entrada;
  logic       commit;
  logic       erro_borda;
  logic       erro_memoria;
  logic       erro_timeout;
  logic [2:0] navios_colocados;
  logic       fase_concluida;

  int checks = 0;
  int errors = 0;

  // reference model of the setup phase
  int m_jogador = 0;
  int m_tipo    = 0;
  int m_placed  = 0;
  int m_done    = 0;

  // expected {jogador, x, y, dir, ori} of each accepted placement, in order
  logic [W-1:0] exp_q[$];

  controlador_posicionamento #(
    .NUM_NAVIOS(NUM_NAVIOS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .confirma(confirma),
    .x_in(x_in),
    .y_in(y_in),
    .direcao_in(direcao_in),
    .orientacao_in(orientacao_in),
    .val_ready(val_ready),
    .val_conflitoBorda(val_conflitoBorda),
    .val_conflitoMemoria(val_conflitoMemoria),
    .val_enable(val_enable),
    .val_tipo(val_tipo),
    .val_direcao(val_direcao),
    .val_orientacao(val_orientacao),
    .val_x1(val_x1),
    .val_y1(val_y1),
    .val_jogador(val_jogador),
    .pedir_entrada(pedir_entrada),
    .commit(commit),
    .erro_borda(erro_borda),
    .erro_memoria(erro_memoria),
    .erro_timeout(erro_timeout),
    .navios_colocados(navios_colocados),
    .fase_concluida(fase_concluida)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, esp);
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return {6'd0, val_enable, val_tipo, val_direcao, val_orientacao, val_x1, val_y1,
            val_jogador, pedir_entrada, commit, erro_borda, erro_memoria, erro_timeout,
            navios_colocados, fase_concluida};
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One placement attempt; the bench plays the validator. Called at a negedge in
  // ESPERA_ENTRADA. atraso = enable cycle (1-based) on which ready is returned.
  task automatic colocar(input logic [3:0] x, input logic [3:0] y, input logic d,
                         input logic [2:0] o, input int atraso, input logic cb,
                         input logic cm, input bit sem_ready);
    int  n_en;
    int  n_commit;
    int  commit_at;
    int  esp_en;
    bit  aceita;
    bit  fim;
    logic [W-1:0] esperado;
    logic [W-1:0] visto;

    aceita = !sem_ready && !cb && !cm;
    esp_en = sem_ready ? TIMEOUT : atraso;
    if (aceita) exp_q.push_back({1'(m_jogador), x, y, d, o});

    x_in = x; y_in = y; direcao_in = d; orientacao_in = o;
    confirma = 1'b1;
    @(negedge clk);
    confirma = 1'b0;
    x_in = 4'($urandom); y_in = 4'($urandom);
    check("enable_in_valida", val_enable, 0);

    n_en = 0; n_commit = 0; commit_at = -1; fim = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      val_ready = 1'b0; val_conflitoBorda = 1'b0; val_conflitoMemoria = 1'b0;
      if (c == 0) check("latency_enable", val_enable, 1);
      if (commit) begin
        n_commit++;
        commit_at = c;
        if (exp_q.size() == 0) begin
          check("commit_extra", commit, 0);
        end else begin
          esperado = exp_q.pop_front();
          visto = {val_jogador, val_x1, val_y1, val_direcao, val_orientacao};
          check("commit_fields", visto, esperado);
        end
      end
      if (val_enable) begin
        n_en++;
        check("fields_stable", {val_x1, val_y1, val_direcao, val_orientacao}, {x, y, d, o});
        if (n_en == 1) begin
          check("val_tipo", val_tipo, m_tipo);
          check("val_jogador", val_jogador, m_jogador);
        end
        if (!sem_ready && n_en == atraso) begin
          val_ready = 1'b1;
          val_conflitoBorda = cb;
          val_conflitoMemoria = cm;
        end
      end
      if (pedir_entrada || fase_concluida) begin
        fim = 1;
        break;
      end
    end
    check("attempt_finished", pedir_entrada | fase_concluida, 1);
    check("enable_cycles", n_en, esp_en);
    check("commit_count", n_commit, aceita ? 1 : 0);
    if (aceita) check("commit_cycle", commit_at, esp_en);
    check("erro_borda", erro_borda, !sem_ready && cb);
    check("erro_memoria", erro_memoria, !sem_ready && cm);
    check("erro_timeout", erro_timeout, sem_ready);

    if (aceita) begin
      m_tipo++;
      m_placed++;
      if (m_placed == NUM_NAVIOS) begin
        if (m_jogador == 0) begin
          m_jogador = 1; m_tipo = 0; m_placed = 0;
        end else begin
          m_done = 1;
        end
      end
    end
    check("navios_colocados", navios_colocados, m_placed);
    check("tipo_after", val_tipo, m_tipo);
    check("jogador_after", val_jogador, m_jogador);
    check("fase_concluida", fase_concluida, m_done);
    check("pedir_entrada", pedir_entrada, !m_done);
  endtask

  initial begin
    int  r;
    bit  sr;
    logic cb, cm;

    rst = 1'b1; start = 1'b0; confirma = 1'b0;
    x_in = '0; y_in = '0; direcao_in = 1'b0; orientacao_in = '0;
    val_ready = 1'b0; val_conflitoBorda = 1'b0; val_conflitoMemoria = 1'b0;

    // reset and idle
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), 0);
    rst = 1'b0;
    @(negedge clk);
    check("after_reset_outputs", all_outputs(), 0);
    for (int i = 0; i < 20; i++) begin
      confirma = 1'(i % 3 == 0);
      @(negedge clk);
      check("idle_enable", val_enable, 0);
      check("idle_pedir", pedir_entrada, 0);
    end
    confirma = 1'b0;

    pulse_start();
    check("pedir_after_start", pedir_entrada, 1);

    // directed: clean, edge conflict, retry, memory conflict, timeout
    colocar(4'd1, 4'd1, 1'b0, 3'd0, 3, 1'b0, 1'b0, 0);
    colocar(4'd7, 4'd0, 1'b0, 3'd0, 2, 1'b1, 1'b0, 0);
    colocar(4'd1, 4'd1, 1'b0, 3'd0, 1, 1'b0, 1'b0, 0);
    colocar(4'd3, 4'd5, 1'b1, 3'd2, 4, 1'b0, 1'b1, 0);
    colocar(4'd3, 4'd5, 1'b1, 3'd2, 1, 1'b0, 1'b0, 1);
    colocar(4'd2, 4'd9, 1'b1, 3'd5, 1, 1'b1, 1'b1, 0);

    // randomized attempts until both fleets are placed
    for (int i = 0; i < 200 && !m_done; i++) begin
      r  = $urandom_range(0, 3);
      cb = (r == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      cm = (r == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      sr = ($urandom_range(0, 15) == 0);
      colocar(4'($urandom), 4'($urandom), 1'($urandom), 3'($urandom),
              $urandom_range(1, 8), cb, cm, sr);
    end
    check("phase_done", fase_concluida, 1);
    check("queue_empty", exp_q.size(), 0);

    // concluded phase ignores start and confirma
    confirma = 1'b1;
    @(negedge clk);
    confirma = 1'b0;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("done_no_enable", val_enable, 0);
      check("done_held", fase_concluida, 1);
      check("done_no_commit", commit, 0);
    end

    // reset in the middle of a validation
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    x_in = 4'd4; y_in = 4'd4; confirma = 1'b1;
    @(negedge clk);
    confirma = 1'b0;
    @(negedge clk);
    check("midrst_enable_before", val_enable, 1);
    val_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("midrst_enable_drop", val_enable, 0);
    check("midrst_no_commit", commit, 0);
    @(negedge clk);
    val_ready = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_idle_outputs", all_outputs(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
